// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage PC generator: FSM states, redirect sources and RAS sizing.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_SEQ = 3'd0,
        SRC_JMP = 3'd1,
        SRC_BR  = 3'd2,
        SRC_RET = 3'd3,
        SRC_EXC = 3'd4
    } src_e;

    localparam int RAS_DEPTH_DFLT = 4;
    localparam int RAS_PW         = $clog2(RAS_DEPTH_DFLT);

    // Pointer width for an arbitrary depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_gen_unit_ras_stack.sv
// Circular return-address stack: overflow overwrites the oldest entry, underflow is only flagged.
module ras_stack
    import pc_gen_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [AW-1:0] push_data_i,
    output logic [AW-1:0] top_o,
    output logic          empty_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam int PW = ptr_w(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          wr_en;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] wrap_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign top_idx     = wrap_dec(ptr_q);
    assign top_o       = mem_q[top_idx];
    assign empty_o     = (cnt_q == '0);
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i) begin
            // The pop supplied the target; the push simply replaces the top slot.
            wr_en  = 1'b1;
            wr_idx = top_idx;
            if (cnt_q == '0) unf_d = 1'b1;
        end else if (pop_i) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = top_idx;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = wrap_inc(ptr_q);
            if (cnt_q == (PW+1)'(DEPTH)) ovf_d = 1'b1;
            else                         cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= push_data_i;
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: priority redirect mux, stall-time pending redirect, FSM and PC register.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int          AW        = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180,
    parameter int          INC       = 4,
    parameter int          RAS_DEPTH = RAS_DEPTH_DFLT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          imem_ready_i,
    input  logic          exc_i,
    input  logic          ret_i,
    input  logic          call_i,
    input  logic          branch_i,
    input  logic [AW-1:0] branch_tgt_i,
    input  logic          jump_i,
    input  logic [AW-1:0] jump_tgt_i,
    output logic [AW-1:0] pc_o,
    output logic          pc_valid_o,
    output logic [AW-1:0] pc_plus_o,
    output logic          ras_empty_o,
    output logic [1:0]    ras_err_o
);

    localparam bit HAS_RAS = (RAS_DEPTH > 0);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, pc_plus, tgt, ras_top;
    logic          pc_valid_q, pc_valid_d;
    logic          pend_pop_q, pend_pop_d, pend_push_q, pend_push_d, pend_flush_q, pend_flush_d;
    logic          ras_push, ras_pop, ras_flush, ras_empty, ras_ovf, ras_unf;
    logic          ret_en, redirect;
    src_e          src;

    assign pc_plus     = pc_q + AW'(INC);
    assign pc_o        = pc_q;
    assign pc_plus_o   = pc_plus;
    assign pc_valid_o  = pc_valid_q;
    assign ras_empty_o = ras_empty;
    assign ras_err_o   = {ras_ovf, ras_unf};
    assign ret_en      = HAS_RAS && ret_i;

    always_comb begin
        src = SRC_SEQ;
        tgt = pc_plus;
        if (exc_i) begin
            src = SRC_EXC;
            tgt = AW'(EXC_VEC);
        end else if (ret_en) begin
            src = SRC_RET;
            tgt = ras_empty ? pc_plus : ras_top;
        end else if (branch_i) begin
            src = SRC_BR;
            tgt = branch_tgt_i;
        end else if (jump_i) begin
            src = SRC_JMP;
            tgt = jump_tgt_i;
        end
    end

    assign redirect = (src != SRC_SEQ);

    // RAS operations are buffered with the pending target so they land on the cycle the redirect does.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        pend_tgt_d   = pend_tgt_q;
        pend_pop_d   = pend_pop_q;
        pend_push_d  = pend_push_q;
        pend_flush_d = pend_flush_q;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        ras_flush    = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (redirect)          pc_d = tgt;
                    else if (imem_ready_i) pc_d = pc_plus;
                    ras_flush = exc_i;
                    ras_pop   = ret_en && !exc_i;
                    ras_push  = call_i && !exc_i;
                end else if (redirect) begin
                    state_d      = ST_PEND;
                    pend_tgt_d   = tgt;
                    pend_flush_d = exc_i;
                    pend_pop_d   = ret_en && !exc_i;
                    pend_push_d  = call_i && !exc_i;
                end
            end
            ST_PEND: begin
                if (stall_i) begin
                    if (exc_i) begin
                        pend_tgt_d   = AW'(EXC_VEC);
                        pend_flush_d = 1'b1;
                        pend_pop_d   = 1'b0;
                        pend_push_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_RUN;
                    if (exc_i) begin
                        pc_d      = AW'(EXC_VEC);
                        ras_flush = 1'b1;
                    end else begin
                        pc_d      = pend_tgt_q;
                        ras_flush = pend_flush_q;
                        ras_pop   = pend_pop_q;
                        ras_push  = pend_push_q;
                    end
                    pend_flush_d = 1'b0;
                    pend_pop_d   = 1'b0;
                    pend_push_d  = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            pc_q         <= AW'(RESET_VEC);
            pc_valid_q   <= 1'b0;
            pend_pop_q   <= 1'b0;
            pend_push_q  <= 1'b0;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            pend_pop_q   <= pend_pop_d;
            pend_push_q  <= pend_push_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

    generate
        if (HAS_RAS) begin : g_ras
            ras_stack #(.DEPTH(RAS_DEPTH), .AW(AW)) u_ras (
                .clk         (clk),
                .rst         (rst),
                .push_i      (ras_push),
                .pop_i       (ras_pop),
                .flush_i     (ras_flush),
                .push_data_i (pc_plus),
                .top_o       (ras_top),
                .empty_o     (ras_empty),
                .overflow_o  (ras_ovf),
                .underflow_o (ras_unf)
            );
        end else begin : g_no_ras
            assign ras_top   = '0;
            assign ras_empty = 1'b1;
            assign ras_ovf   = 1'b0;
            assign ras_unf   = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: stimulus queues the expected post-edge state, a negedge monitor checks it.
module tb_pc_gen_unit;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic [1:0]  err;
        logic        empty;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall_i, imem_ready_i, exc_i, ret_i, call_i, branch_i, jump_i;
    logic [31:0] branch_tgt_i, jump_tgt_i, pc_o, pc_plus_o;
    logic        pc_valid_o, ras_empty_o;
    logic [1:0]  ras_err_o;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  exp_err   = 2'b00;
    logic        exp_empty = 1'b1;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .imem_ready_i (imem_ready_i),
        .exc_i        (exc_i),
        .ret_i        (ret_i),
        .call_i       (call_i),
        .branch_i     (branch_i),
        .branch_tgt_i (branch_tgt_i),
        .jump_i       (jump_i),
        .jump_tgt_i   (jump_tgt_i),
        .pc_o         (pc_o),
        .pc_valid_o   (pc_valid_o),
        .pc_plus_o    (pc_plus_o),
        .ras_empty_o  (ras_empty_o),
        .ras_err_o    (ras_err_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a state, compare it against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc_valid", 32'(pc_valid_o), 32'(e.vld));
            chk("pc",       pc_o, e.pc);
            chk("ras_err",  32'(ras_err_o), 32'(e.err));
            chk("ras_empty", 32'(ras_empty_o), 32'(e.empty));
        end
    end

    task automatic cyc(input logic [31:0] pc, input logic vld);
        exp_t e;
        @(posedge clk);
        e.pc = pc; e.vld = vld; e.err = exp_err; e.empty = exp_empty;
        sb_q.push_back(e);
        #1;
        exc_i = 0; ret_i = 0; call_i = 0; branch_i = 0; jump_i = 0;
    endtask

    task automatic jmp(input logic [31:0] t, input logic call);
        jump_i = 1; jump_tgt_i = t; call_i = call;
    endtask

    initial begin
        rst = 0; stall_i = 0; imem_ready_i = 1; exc_i = 0; ret_i = 0; call_i = 0;
        branch_i = 0; jump_i = 0; branch_tgt_i = '0; jump_tgt_i = '0;
        cyc(32'h0, 0);
        cyc(32'h0, 0);

        // Reset release and sequential fetch
        rst = 1;
        cyc(32'h0, 1); cyc(32'h4, 1); cyc(32'h8, 1); cyc(32'hC, 1);

        // Priority between simultaneous redirects
        jmp(32'h10, 0);                       cyc(32'h10, 1);
        branch_i = 1; branch_tgt_i = 32'h100; jmp(32'h200, 0);
        cyc(32'h100, 1);
        exc_i = 1; branch_i = 1; branch_tgt_i = 32'h400;
        cyc(32'h8000_0180, 1);

        // Stall buffers a jump; a later non-exception redirect is dropped
        jmp(32'h20, 0);                       cyc(32'h20, 1);
        stall_i = 1; jmp(32'h300, 0);         cyc(32'h20, 1);
        jmp(32'h600, 0);                      cyc(32'h20, 1);
        cyc(32'h20, 1);
        stall_i = 0;                          cyc(32'h300, 1);
        cyc(32'h304, 1);

        // Five calls into a 4-deep RAS, then returns and underflow
        jmp(32'h0, 0);                        cyc(32'h0, 1);
        exp_empty = 0;
        jmp(32'h10, 1);                       cyc(32'h10, 1);
        jmp(32'h20, 1);                       cyc(32'h20, 1);
        jmp(32'h30, 1);                       cyc(32'h30, 1);
        jmp(32'h40, 1);                       cyc(32'h40, 1);
        exp_err = 2'b10;
        jmp(32'h50, 1);                       cyc(32'h50, 1);
        ret_i = 1;                            cyc(32'h44, 1);
        ret_i = 1;                            cyc(32'h34, 1);
        ret_i = 1;                            cyc(32'h24, 1);
        exp_empty = 1;
        ret_i = 1;                            cyc(32'h14, 1);
        exp_err = 2'b11;
        ret_i = 1;                            cyc(32'h18, 1);

        // Exception replaces a pending branch during a stall
        stall_i = 1; branch_i = 1; branch_tgt_i = 32'h500; cyc(32'h18, 1);
        exc_i = 1;                            cyc(32'h18, 1);
        stall_i = 0;                          cyc(32'h8000_0180, 1);

        // Wrap-around and imem_ready hold
        jmp(32'hFFFF_FFFC, 0);                cyc(32'hFFFF_FFFC, 1);
        chk("pc_plus_wrap", pc_plus_o, 32'h0);
        cyc(32'h0, 1);
        imem_ready_i = 0;                     cyc(32'h0, 1);
        cyc(32'h0, 1);
        imem_ready_i = 1;                     cyc(32'h4, 1);

        // Reset while a redirect is pending
        jmp(32'h20, 0);                       cyc(32'h20, 1);
        stall_i = 1; jmp(32'h300, 0);         cyc(32'h20, 1);
        rst = 0; exp_err = 2'b00; exp_empty = 1;
        cyc(32'h0, 0);
        rst = 1; stall_i = 0;                 cyc(32'h0, 1);
        cyc(32'h4, 1);
        cyc(32'h8, 1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
